// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD text buffer arbiter and its RAM.
package lcd_pkg;

    localparam int         LCD_ADDR_W     = 6;
    localparam int         LCD_DATA_W     = 8;
    localparam int         LCD_LINE_WIDTH = 16;
    localparam logic [7:0] LCD_SPACE_CHAR = 8'h20;

    typedef enum logic [2:0] {
        CLEAR   = 3'd0,
        IDLE    = 3'd1,
        ARM     = 3'd2,
        PRINT   = 3'd3,
        HOLDOFF = 3'd4
    } lcd_state_e;

    // Buffer address of a (line, column) character cell.
    function automatic logic [LCD_ADDR_W-1:0] lcd_addr(input logic [1:0] line,
                                                       input logic [3:0] col);
        return LCD_ADDR_W'(int'(line) * LCD_LINE_WIDTH + int'(col));
    endfunction

endpackage

// File: rtl/lcd_text_ram.sv
// 1-write/1-read character RAM: synchronous write, registered read-before-write.
module lcd_text_ram #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Same-cycle write to rd_addr is not visible until the following read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/lcd_text_arbiter.sv
// Character buffer owner: clears on reset, arbitrates two writers, schedules refreshes.
// Define LCD_ARB_FIXED_PRIO_EN for fixed client-0 priority instead of round-robin.
module lcd_text_arbiter
    import lcd_pkg::*;
#(
    parameter int ADDR_W             = LCD_ADDR_W,
    parameter int DATA_W             = LCD_DATA_W,
    parameter int MIN_REFRESH_CYCLES = 2500,
    parameter int ARM_TIMEOUT        = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr0_valid,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    output logic              wr0_ready,
    input  logic              wr1_valid,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    output logic              wr1_ready,
    input  logic [ADDR_W-1:0] drv_addr,
    output logic [DATA_W-1:0] drv_data,
    input  logic              drv_busy,
    output logic              drv_trg,
    output logic              init_done,
    output lcd_state_e        fsm_state
);

    localparam int HOLD_W = $clog2(MIN_REFRESH_CYCLES + 1);
    localparam int ARM_W  = $clog2(ARM_TIMEOUT + 1);

    lcd_state_e        state;
    logic [ADDR_W-1:0] ptr;
    logic              dirty;
    logic [HOLD_W-1:0] holdoff;
    logic [ARM_W-1:0]  arm_cnt;

    logic              grant0;
    logic              grant1;
    logic              wr_any;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;

    // Handshake: a client write transfers in the cycle where valid && ready.
    // ready is the combinational grant; it is never asserted during CLEAR.
`ifdef LCD_ARB_FIXED_PRIO_EN
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state != CLEAR) begin
            grant0 = wr0_valid;
            grant1 = wr1_valid && !wr0_valid;
        end
    end
`else
    logic rr;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state != CLEAR) begin
            if (wr0_valid && wr1_valid) begin
                grant0 = !rr;
                grant1 = rr;
            end else begin
                grant0 = wr0_valid;
                grant1 = wr1_valid;
            end
        end
    end

    // The pointer only moves on a contested cycle; lone requesters leave it alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr <= 1'b0;
        end else if (grant0 && wr1_valid) begin
            rr <= 1'b1;
        end else if (grant1 && wr0_valid) begin
            rr <= 1'b0;
        end
    end
`endif

    assign wr0_ready = grant0;
    assign wr1_ready = grant1;
    assign wr_any    = grant0 || grant1;
    assign fsm_state = state;

    always_comb begin
        ram_we    = wr_any;
        ram_waddr = grant1 ? wr1_addr : wr0_addr;
        ram_wdata = grant1 ? wr1_data : wr0_data;
        if (state == CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = ptr;
            ram_wdata = DATA_W'(LCD_SPACE_CHAR);
        end
    end

    lcd_text_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (ram_we),
        .wr_addr (ram_waddr),
        .wr_data (ram_wdata),
        .rd_addr (drv_addr),
        .rd_data (drv_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= CLEAR;
            ptr       <= '0;
            dirty     <= 1'b0;
            holdoff   <= '0;
            arm_cnt   <= '0;
            drv_trg   <= 1'b0;
            init_done <= 1'b0;
        end else begin
            drv_trg <= 1'b0;
            case (state)
                CLEAR: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == '1) begin
                        init_done <= 1'b1;
                        dirty     <= 1'b1;
                        state     <= IDLE;
                    end
                end
                IDLE: begin
                    if (dirty && !drv_busy && holdoff == '0) begin
                        drv_trg <= 1'b1;
                        dirty   <= 1'b0;
                        arm_cnt <= '0;
                        state   <= ARM;
                    end
                end
                ARM: begin
                    if (drv_busy) begin
                        state <= PRINT;
                    end else if (arm_cnt == ARM_W'(ARM_TIMEOUT - 1)) begin
                        // Driver never started: keep the refresh pending.
                        dirty   <= 1'b1;
                        holdoff <= HOLD_W'(MIN_REFRESH_CYCLES);
                        state   <= HOLDOFF;
                    end else begin
                        arm_cnt <= arm_cnt + 1'b1;
                    end
                end
                PRINT: begin
                    if (!drv_busy) begin
                        holdoff <= HOLD_W'(MIN_REFRESH_CYCLES);
                        state   <= HOLDOFF;
                    end
                end
                HOLDOFF: begin
                    if (holdoff == '0) begin
                        state <= IDLE;
                    end else begin
                        holdoff <= holdoff - 1'b1;
                    end
                end
                default: state <= CLEAR;
            endcase
            // Placed last so an accepted write beats the trigger's clear.
            if (wr_any) begin
                dirty <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lcd_text_arbiter.sv
// Directed bench for lcd_text_arbiter: clear, writes, arbitration, refresh pacing, reset.
module tb_lcd_text_arbiter;
    import lcd_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr0_valid = 1'b0;
    logic [5:0] wr0_addr = '0;
    logic [7:0] wr0_data = '0;
    logic       wr0_ready;
    logic       wr1_valid = 1'b0;
    logic [5:0] wr1_addr = '0;
    logic [7:0] wr1_data = '0;
    logic       wr1_ready;
    logic [5:0] drv_addr = '0;
    logic [7:0] drv_data;
    logic       drv_busy = 1'b0;
    logic       drv_trg;
    logic       init_done;
    lcd_state_e fsm_state;

    int n_cmp = 0;
    int n_err = 0;
    int trg_cnt = 0;
    logic [7:0] exp_q[$];

    lcd_text_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .wr0_valid (wr0_valid),
        .wr0_addr  (wr0_addr),
        .wr0_data  (wr0_data),
        .wr0_ready (wr0_ready),
        .wr1_valid (wr1_valid),
        .wr1_addr  (wr1_addr),
        .wr1_data  (wr1_data),
        .wr1_ready (wr1_ready),
        .drv_addr  (drv_addr),
        .drv_data  (drv_data),
        .drv_busy  (drv_busy),
        .drv_trg   (drv_trg),
        .init_done (init_done),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (drv_trg) trg_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_chk(input string tag, input logic [5:0] addr, input logic [7:0] exp);
        drv_addr = addr;
        tick();
        check(tag, 32'(drv_data), 32'(exp));
    endtask

    task automatic wait_trg(input string tag, input int max, output int n);
        n = 0;
        while (!drv_trg && n < max) begin
            tick();
            n++;
        end
        check(tag, 32'(drv_trg), 32'd1);
    endtask

    initial begin
        int n;
        int c0;
        logic [5:0] rb_addr [4];
        rb_addr[0] = 6'd1;
        rb_addr[1] = 6'd2;
        rb_addr[2] = 6'd5;
        rb_addr[3] = 6'd10;

        // Reset values
        #22;
        check("rst_rdy0", 32'(wr0_ready), 32'd0);
        check("rst_rdy1", 32'(wr1_ready), 32'd0);
        check("rst_trg", 32'(drv_trg), 32'd0);
        check("rst_data", 32'(drv_data), 32'd0);
        check("rst_init", 32'(init_done), 32'd0);
        check("rst_state", 32'(fsm_state), 32'(CLEAR));

        // Clear sequence: init_done after exactly 64 edges, writes blocked meanwhile
        @(negedge clk);
        rst = 1'b1;
        wr0_valid = 1'b1;
        wr0_addr  = 6'd0;
        wr0_data  = 8'h99;
        for (int i = 1; i <= 64; i++) begin
            tick();
            if (i == 10) begin
                check("clr_rdy0", 32'(wr0_ready), 32'd0);
                wr0_valid = 1'b0;
            end
            if (i == 63) check("init_early", 32'(init_done), 32'd0);
            if (i == 64) begin
                check("init_done", 32'(init_done), 32'd1);
                check("idle_after_clr", 32'(fsm_state), 32'(IDLE));
            end
        end

        // First refresh fires straight away, one cycle wide
        tick();
        check("trg_first", 32'(drv_trg), 32'd1);
        drv_busy = 1'b1;
        tick();
        check("trg_width", 32'(drv_trg), 32'd0);
        check("st_print", 32'(fsm_state), 32'(PRINT));
        repeat (20) tick();
        drv_busy = 1'b0;
        tick();
        check("st_holdoff", 32'(fsm_state), 32'(HOLDOFF));

        read_chk("clr_rd0", 6'd0, 8'h20);
        read_chk("clr_rd37", 6'd37, 8'h20);
        read_chk("clr_rd63", 6'd63, 8'h20);

        // Single write with read-before-write on the same address
        wr0_valid = 1'b1;
        wr0_addr  = 6'd5;
        wr0_data  = 8'h41;
        drv_addr  = 6'd5;
        #1;
        check("w0_ready", 32'(wr0_ready), 32'd1);
        tick();
        wr0_valid = 1'b0;
        check("rbw_old", 32'(drv_data), 32'h20);
        tick();
        check("w0_visible", 32'(drv_data), 32'h41);

        wait_trg("trg_after_write", 3000, n);

        // Long print with a mid-print write and contested writes
        drv_busy = 1'b1;
        for (int i = 1; i <= 500; i++) begin
            int k;
            k = i - 200;
            wr0_valid = 1'b0;
            wr1_valid = 1'b0;
            if (i == 100) begin
                wr1_valid = 1'b1;
                wr1_addr  = 6'd10;
                wr1_data  = 8'h42;
            end
            if (i >= 200 && i <= 203) begin
                wr0_valid = 1'b1;
                wr0_addr  = 6'd1;
                wr0_data  = 8'(8'h50 + k);
                wr1_valid = 1'b1;
                wr1_addr  = 6'd2;
                wr1_data  = 8'(8'h60 + k);
            end
            #1;
            if (i == 100) check("print_w_rdy", 32'(wr1_ready), 32'd1);
            if (i >= 200 && i <= 203) begin
`ifdef LCD_ARB_FIXED_PRIO_EN
                check("arb_g0", 32'(wr0_ready), 32'd1);
                check("arb_g1", 32'(wr1_ready), 32'd0);
`else
                check("arb_g0", 32'(wr0_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
                check("arb_g1", 32'(wr1_ready), (k % 2 == 1) ? 32'd1 : 32'd0);
`endif
            end
            tick();
        end
        wr0_valid = 1'b0;
        wr1_valid = 1'b0;
        drv_busy  = 1'b0;
        wait_trg("trg_followup", 3000, n);
        check("followup_spacing", 32'(n >= 2500 && n <= 2510), 32'd1);

        // Serve the follow-up; nothing else is pending so no further trigger
        drv_busy = 1'b1;
        repeat (10) tick();
        drv_busy = 1'b0;
        c0 = trg_cnt;
        repeat (2700) tick();
        check("one_extra_only", 32'(trg_cnt), 32'(c0));
        check("st_idle", 32'(fsm_state), 32'(IDLE));

`ifdef LCD_ARB_FIXED_PRIO_EN
        exp_q.push_back(8'h53);
        exp_q.push_back(8'h20);
`else
        exp_q.push_back(8'h52);
        exp_q.push_back(8'h63);
`endif
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h42);
        for (int i = 0; i < 4; i++) begin
            read_chk("readback", rb_addr[i], exp_q.pop_front());
        end

        // Arm timeout: driver never goes busy
        wr0_valid = 1'b1;
        wr0_addr  = 6'd20;
        wr0_data  = 8'h43;
        tick();
        wr0_valid = 1'b0;
        wait_trg("trg_arm", 20, n);
        repeat (14) tick();
        check("arm_wait", 32'(fsm_state), 32'(ARM));
        tick();
        check("arm_timeout", 32'(fsm_state), 32'(HOLDOFF));
        wait_trg("trg_retry", 2700, n);
        check("retry_spacing", 32'(n >= 2500 && n <= 2510), 32'd1);

        // Reset in the middle of a print
        drv_busy = 1'b1;
        tick();
        tick();
        check("pre_rst_print", 32'(fsm_state), 32'(PRINT));
        wr0_valid = 1'b1;
        #3;
        rst = 1'b0;
        #1;
        check("mid_rst_state", 32'(fsm_state), 32'(CLEAR));
        check("mid_rst_init", 32'(init_done), 32'd0);
        check("mid_rst_data", 32'(drv_data), 32'd0);
        check("mid_rst_trg", 32'(drv_trg), 32'd0);
        check("mid_rst_rdy0", 32'(wr0_ready), 32'd0);
        drv_busy  = 1'b0;
        wr0_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (64) tick();
        check("reinit_done", 32'(init_done), 32'd1);
        read_chk("reclr_rd5", 6'd5, 8'h20);
        read_chk("reclr_rd20", 6'd20, 8'h20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lcd_text_arbiter.md
# lcd_text_arbiter

Owns the 64-byte character buffer (4 lines × 16 chars) that feeds the HD44780 4-bit driver's data-fetch port. Arbitrates byte writes from two client ports. Schedules driver refreshes by pulsing the driver trigger whenever the buffer is dirty and the driver is idle. Enforces a minimum refresh interval. Sits between application logic and the `hd44780` block, in the same 250 kHz clock domain.

## Interface
- `ADDR_W`, 6: buffer address width; depth = 2^ADDR_W = 64.
- `DATA_W`, 8: character width.
- `MIN_REFRESH_CYCLES`, 2500: idle cycles (10 ms at 250 kHz) after a print before the next trigger.
- `ARM_TIMEOUT`, 15: cycles to wait for `drv_busy` to rise after a trigger.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `wr0_valid` in 1: client 0 write request.
- `wr0_addr` in ADDR_W: client 0 address.
- `wr0_data` in DATA_W: client 0 byte.
- `wr0_ready` out 1: client 0 write accepted this cycle.
- `wr1_valid` / `wr1_addr` / `wr1_data` / `wr1_ready`: same for client 1.
- `drv_addr` in ADDR_W: driver read address.
- `drv_data` out DATA_W: registered read data.
- `drv_busy` in 1: driver busy.
- `drv_trg` out 1: one-cycle refresh trigger to the driver.
- `init_done` out 1: buffer clear complete.

## Operation
- **Reset values:** `wr0_ready=0`, `wr1_ready=0`, `drv_trg=0`, `drv_data=0`, `init_done=0`. State=CLEAR, clear pointer=0, dirty=0, rr pointer=client 0, holdoff=0.
- **CLEAR:** writes 0x20 to address `ptr` each cycle, 64 cycles. Both readies are held at 0. On `ptr=63`: set `init_done=1` and dirty=1, then go to IDLE.
- **Writes:** accepted in every state except CLEAR. At most one write per cycle.
  - `wrN_ready` is combinational: it equals grant. A write happens iff valid&&ready.
  - Each accepted write sets dirty=1.
- **Arbitration:** round-robin.
  - If both clients are valid, the rr-pointer client wins. The pointer then moves to the other client.
  - A lone requester always wins and the pointer is unchanged.
- **IDLE:** if dirty && !`drv_busy` && holdoff==0, pulse `drv_trg`, clear dirty, and go to ARM.
- **ARM:**
  - On `drv_busy=1`, go to PRINT.
  - If `ARM_TIMEOUT` cycles pass without `drv_busy` rising, set dirty=1, load holdoff, and go to HOLDOFF.
- **PRINT:** on `drv_busy` falling (0 sampled), load holdoff=`MIN_REFRESH_CYCLES` and go to HOLDOFF.
- **HOLDOFF:** decrement holdoff to 0, then go to IDLE. Writes during ARM, PRINT or HOLDOFF re-set dirty, so exactly one follow-up refresh occurs.
- **Read port:** `drv_data` ← mem[`drv_addr`] every cycle, independent of state.
- **Simultaneous write and read, same address:** read returns the old byte (read-before-write).
- **Dirty conflict:** a write in the same cycle as `drv_trg` leaves dirty=1 (set wins over clear).
- **Reset mid-operation:** everything returns to CLEAR and the buffer is re-cleared.

## Timing
- Write latency is 1 cycle: the byte is visible on `drv_data` 2 cycles after acceptance (1 write + 1 registered read).
- Read latency is 1 cycle from `drv_addr` to `drv_data`.
- `drv_trg` is high for exactly 1 cycle, and no more than once per ARM entry.
- Minimum spacing between triggers is print duration + `MIN_REFRESH_CYCLES` + 1.
- CLEAR lasts 64 cycles. `init_done` rises in cycle 65 after reset release.

## Configuration
- `LCD_ARB_FIXED_PRIO_EN` defined: client 0 always wins on conflict, and the rr pointer is removed.
- Not defined: round-robin as described above.

## Structure
- **Package `lcd_pkg`:** state enum {CLEAR, IDLE, ARM, PRINT, HOLDOFF}, `LCD_ADDR_W=6`, `LCD_DATA_W=8`, `LCD_LINE_WIDTH=16`, `LCD_SPACE_CHAR=8'h20`.
- **Sub-module `lcd_text_ram`:** 1-write/1-read, synchronous write, registered read, read-before-write.
- Arbiter, FSM and holdoff counter live in the top module.

## Test plan
- **Reset release:** `init_done` rises at cycle 65; reading any address gives `drv_data=0x20`. With `drv_busy=0`, `drv_trg` pulses once.
- **Single write:** client 0 writes 0x41 at addr 5 → `wr0_ready=1` in the same cycle; `drv_addr=5` gives 0x41 two cycles later; `drv_trg` pulses after holdoff.
- **Simultaneous writes:** both valid for 4 cycles at addrs 1 and 2 → grants alternate 0,1,0,1. In fixed-priority mode, client 0 is granted all 4 cycles.
- **Write during PRINT:** `drv_busy` high for 500 cycles with a write at cycle 100 → exactly one extra `drv_trg`, no earlier than 2500 cycles after busy falls.
- **ARM timeout:** `drv_busy` held 0 after the trigger → return to HOLDOFF after 15 cycles with dirty=1; retrigger after 2500 cycles.
- **Reset mid-PRINT:** assert `rst` → all outputs return to reset values; CLEAR restarts and the buffer reads 0x20.
